// File: rtl/uc_multiciclo.sv
// Multicycle control unit for the 8-bit CPU: FETCH/DECODE/EXEC/HALT sequencer driving the datapath controls.
// Optional retired-instruction counter is built only when UC_PERF_EN is defined.
module uc_multiciclo (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [5:0]  opcode,
  input  logic        z,
  output logic        s_inc,
  output logic        s_inm,
  output logic        we3,
  output logic        wez,
  output logic        pc_we,
  output logic [2:0]  op_alu,
  output logic        halted,
  output logic [15:0] retired
);

  typedef enum logic [1:0] {
    FETCH  = 2'b00,
    DECODE = 2'b01,
    EXEC   = 2'b10,
    HALT   = 2'b11
  } state_t;

  state_t      state_reg;
  state_t      state_next;
  logic [5:0]  ir_reg;
  logic        ir_unused;

  // Only IR[5:2] selects the instruction class; the low bits travel along unused.
  assign ir_unused = ^ir_reg[1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= FETCH;
      ir_reg    <= 6'b000000;
    end else begin
      state_reg <= state_next;
      if (state_reg == DECODE) begin
        ir_reg <= opcode;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FETCH:   state_next = stall ? FETCH : DECODE;
      DECODE:  state_next = EXEC;
      EXEC:    state_next = (ir_reg[5:2] == 4'b1111) ? HALT : FETCH;
      HALT:    state_next = HALT;
      default: state_next = FETCH;
    endcase
  end

  // Selects follow IR in every state; enables are gated to the single EXEC cycle.
  always_comb begin
    logic in_exec;
    in_exec = (state_reg == EXEC);
    s_inc   = 1'b1;
    s_inm   = 1'b0;
    op_alu  = ir_reg[4:2];
    we3     = 1'b0;
    wez     = 1'b0;
    pc_we   = 1'b0;
    halted  = (state_reg == HALT);
    if (!ir_reg[5]) begin
      we3   = in_exec;
      wez   = in_exec;
      pc_we = in_exec;
    end else begin
      case (ir_reg[4:2])
        3'b000: begin
          s_inm = 1'b1;
          we3   = in_exec;
          pc_we = in_exec;
        end
        3'b001: begin
          s_inc = 1'b0;
          pc_we = in_exec;
        end
        3'b010: begin
          s_inc = ~z;
          pc_we = in_exec;
        end
        3'b011: begin
          s_inc = z;
          pc_we = in_exec;
        end
        3'b111: begin
          pc_we = 1'b0;
        end
        default: begin
          pc_we = in_exec;
        end
      endcase
    end
  end

`ifdef UC_PERF_EN
  logic [15:0] retired_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired_reg <= 16'h0000;
    end else if (state_reg == EXEC && state_next == FETCH) begin
      retired_reg <= retired_reg + 16'h0001;
    end
  end

  assign retired = retired_reg;
`else
  assign retired = 16'h0000;
`endif

endmodule

// File: tb/tb_uc_multiciclo.sv
// Directed bench for uc_multiciclo: steps one cycle at a time and checks the control vector
// {halted, pc_we, wez, we3, s_inm, s_inc, op_alu} against hand-computed values.
module tb_uc_multiciclo;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [5:0]  opcode;
  logic        z;
  logic        s_inc;
  logic        s_inm;
  logic        we3;
  logic        wez;
  logic        pc_we;
  logic [2:0]  op_alu;
  logic        halted;
  logic [15:0] retired;

  int tests_run;
  int tests_failed;

  uc_multiciclo dut (
    .clk     (clk),
    .reset   (reset),
    .stall   (stall),
    .opcode  (opcode),
    .z       (z),
    .s_inc   (s_inc),
    .s_inm   (s_inm),
    .we3     (we3),
    .wez     (wez),
    .pc_we   (pc_we),
    .op_alu  (op_alu),
    .halted  (halted),
    .retired (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [8:0] V_RESET = 9'b0_0_0_0_0_1_000;
  localparam logic [8:0] V_ALU   = 9'b0_1_1_1_0_1_101;
  localparam logic [8:0] V_JZ_Z1 = 9'b0_1_0_0_0_0_010;
  localparam logic [8:0] V_JZ_Z0 = 9'b0_1_0_0_0_1_010;
  localparam logic [8:0] V_JNZ1  = 9'b0_1_0_0_0_1_011;
  localparam logic [8:0] V_JMP   = 9'b0_1_0_0_0_0_001;
  localparam logic [8:0] V_NOP   = 9'b0_1_0_0_0_1_100;
  localparam logic [8:0] V_LI    = 9'b0_1_0_1_1_1_000;
  localparam logic [8:0] V_HEXEC = 9'b0_0_0_0_0_1_111;
  localparam logic [8:0] V_HALT  = 9'b1_0_0_0_0_1_111;

`ifdef UC_PERF_EN
  localparam logic [15:0] RET_AFTER_RUN = 16'd7;
`else
  localparam logic [15:0] RET_AFTER_RUN = 16'd0;
`endif

  function automatic logic [8:0] ctl_vec();
    return {halted, pc_we, wez, we3, s_inm, s_inc, op_alu};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_vec(input string tag, input logic [8:0] exp);
    logic [8:0] obs;
    obs = ctl_vec();
    tests_run++;
    $display("[TB] %s ctl=%b exp=%b", tag, obs, exp);
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: ctl observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_en_off(input string tag);
    logic [3:0] obs;
    obs = {halted, pc_we, wez, we3};
    tests_run++;
    $display("[TB] %s en=%b exp=0000", tag, obs);
    assert (obs === 4'b0000) else begin
      tests_failed++;
      $error("FAIL %s: {halted,pc_we,wez,we3} observed %b expected 0000", tag, obs);
    end
  endtask

  task automatic check_ret(input string tag, input logic [15:0] exp);
    tests_run++;
    $display("[TB] %s retired=%0d exp=%0d", tag, retired, exp);
    assert (retired === exp) else begin
      tests_failed++;
      $error("FAIL %s: retired observed %h expected %h", tag, retired, exp);
    end
  endtask

  // Caller is positioned 1 time unit after the edge that entered FETCH.
  task automatic run_instr(input string tag, input logic [5:0] op, input logic zv,
                           input logic [8:0] exp_exec);
    opcode = op;
    z      = zv;
    stall  = 1'b0;
    #1;
    check_en_off({tag, "_F"});
    tick();
    check_en_off({tag, "_D"});
    tick();
    #1;
    check_vec({tag, "_E"}, exp_exec);
    tick();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset  = 1'b0;
    stall  = 1'($urandom);
    opcode = 6'($urandom);
    z      = 1'($urandom);

    #1;
    check_vec("reset_async", V_RESET);
    check_ret("reset_ret", 16'd0);
    for (int i = 0; i < 3; i++) begin
      stall  = 1'($urandom);
      opcode = 6'($urandom);
      z      = 1'($urandom);
      tick();
      check_vec("reset_hold", V_RESET);
    end
    reset = 1'b1;

    run_instr("alu",    6'b010100, 1'b0, V_ALU);
    run_instr("jz_z1",  6'b101000, 1'b1, V_JZ_Z1);
    run_instr("jz_z0",  6'b101000, 1'b0, V_JZ_Z0);
    run_instr("jnz_z1", 6'b101100, 1'b1, V_JNZ1);
    run_instr("jmp",    6'b100100, 1'b0, V_JMP);
    run_instr("nop",    6'b110000, 1'b1, V_NOP);

    // Four stalled FETCH cycles, then load-immediate; stall in DECODE/EXEC is ignored.
    opcode = 6'b100000;
    stall  = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      #1;
      check_en_off("stall_F");
      tick();
    end
    stall = 1'b0;
    #1;
    check_en_off("stall_F5");
    tick();
    stall = 1'b1;
    #1;
    check_en_off("stall_D6");
    tick();
    #1;
    check_vec("stall_li_E7", V_LI);
    stall = 1'b0;
    tick();
    #1;
    check_en_off("after_li_F");
    check_ret("ret_after_run", RET_AFTER_RUN);

    run_instr("halt", 6'b111100, 1'b0, V_HEXEC);
    for (int c = 0; c < 20; c++) begin
      stall  = 1'($urandom);
      opcode = 6'($urandom);
      z      = 1'($urandom);
      #1;
      check_vec("halt_hold", V_HALT);
      tick();
    end
    check_ret("ret_halt", RET_AFTER_RUN);

    // Leave HALT by reset, then abort an ALU op mid-EXEC.
    reset = 1'b0;
    #1;
    check_vec("halt_reset", V_RESET);
    tick();
    reset  = 1'b1;
    opcode = 6'b010100;
    stall  = 1'b0;
    #1;
    check_en_off("mid_F");
    tick();
    tick();
    #1;
    check_vec("mid_E", V_ALU);
    reset = 1'b0;
    #1;
    check_vec("mid_reset_now", V_RESET);
    tick();
    check_vec("mid_reset_edge", V_RESET);
    check_ret("mid_reset_ret", 16'd0);
    reset = 1'b1;
    tick();
    check_en_off("post_reset_D");
    tick();
    #1;
    check_vec("post_reset_E", V_ALU);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
